linebuf_ctrl: RTL and testbench

//  Sequencer for the 5x5 line buffer in front of the conv engine.
//  On start, it latches the image/filter config and pulses buf_en to arm the line buffer.
//  It then streams img_size*img_size pixel reads from the feature-map memory, one per cycle.
//  It tags every line-buffer window position with win_valid plus the window's top-left
//  (row, col), aligned to the cycle the window registers hold that window.

---
 rtl/linebuf_ctrl.sv | 158 +++++++++++++++
 tb/tb_linebuf_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/linebuf_ctrl.sv
// linebuf_ctrl: sequencer for the 5x5 line buffer in front of the conv engine.
// A start request with a legal configuration does the following, in order:
//   - latches the configuration,
//   - pulses buf_en,
//   - streams img_size*img_size raster-order reads, one per cycle,
//   - drains the tag pipe,
//   - pulses done.
// Window tags travel through a PIPE_LAT-deep delay line, so that win_valid/row/col
// line up with the cycle the window registers hold that window.
//
// state  | meaning
// IDLE   | waiting for start; an illegal config pulses err
// PRIME  | one cycle, buf_en arms the line buffer
// STREAM | one read per cycle, pushes window tags
// DRAIN  | PIPE_LAT cycles, flushing the last tags out
// DONE   | one cycle, done pulse
//
// Ports:
//   clk, xrst          clock, synchronous active-high reset
//   start              single-cycle request to process one image
//   img_size, fil_size image side / filter side, sampled at accepted start
//   mem_re, mem_addr   feature-map read enable and raster address
//   buf_en             line-buffer start pulse
//   win_valid/row/col  tag of the complete window currently in the window registers
//   busy, done, err    status: not idle, completion pulse, rejected-start pulse
module linebuf_ctrl #(
    parameter int LWIDTH   = 9,
    parameter int AWIDTH   = 18,
    parameter int MAXFIL   = 5,
    parameter int PIPE_LAT = 4
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              start,
    input  logic [LWIDTH-1:0] img_size,
    input  logic [LWIDTH-1:0] fil_size,
    output logic              mem_re,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              buf_en,
    output logic              win_valid,
    output logic [LWIDTH-1:0] win_row,
    output logic [LWIDTH-1:0] win_col,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [LWIDTH-1:0] img_q, fil_q, row_q, col_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DW-1:0]     drain_cnt;
    logic              err_q;

    logic              tag_v   [PIPE_LAT];
    logic [LWIDTH-1:0] tag_row [PIPE_LAT];
    logic [LWIDTH-1:0] tag_col [PIPE_LAT];

    logic              cfg_ok, accept, last_pix, drain_tc;
    logic              v_in;
    logic [LWIDTH-1:0] fil_m1, row_in, col_in;

    assign cfg_ok   = (fil_size != '0) && (fil_size <= LWIDTH'(MAXFIL)) && (fil_size <= img_size);
    assign accept   = (state == ST_IDLE) && start && cfg_ok;
    assign last_pix = (row_q == img_q - LWIDTH'(1)) && (col_q == img_q - LWIDTH'(1));
    assign drain_tc = (drain_cnt == '0);

    // Window top-left is the current pixel minus (fil_size-1) in each direction.
    // Outside STREAM the pushed tag is all zero.
    assign fil_m1 = fil_q - LWIDTH'(1);
    assign v_in   = (state == ST_STREAM) && (row_q >= fil_m1) && (col_q >= fil_m1);
    assign row_in = v_in ? row_q - fil_m1 : '0;
    assign col_in = v_in ? col_q - fil_m1 : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept)   state_nxt = ST_PRIME;
            ST_PRIME:                state_nxt = ST_STREAM;
            ST_STREAM: if (last_pix) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (drain_tc) state_nxt = ST_DONE;
            ST_DONE:                 state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (xrst) begin
            state     <= ST_IDLE;
            img_q     <= '0;
            fil_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            addr_q    <= '0;
            drain_cnt <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_v[i]   <= 1'b0;
                tag_row[i] <= '0;
                tag_col[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            err_q <= (state == ST_IDLE) && start && !cfg_ok;

            if (accept) begin
                img_q  <= img_size;
                fil_q  <= fil_size;
                row_q  <= '0;
                col_q  <= '0;
                addr_q <= '0;
            end else if ((state == ST_STREAM) && !last_pix) begin
                // Final address is held after the last read.
                addr_q <= addr_q + AWIDTH'(1);
                if (col_q == img_q - LWIDTH'(1)) begin
                    col_q <= '0;
                    row_q <= row_q + LWIDTH'(1);
                end else begin
                    col_q <= col_q + LWIDTH'(1);
                end
            end

            if ((state == ST_STREAM) && last_pix)
                drain_cnt <= DW'(PIPE_LAT - 1);
            else if ((state == ST_DRAIN) && !drain_tc)
                drain_cnt <= drain_cnt - DW'(1);

            tag_v[0]   <= v_in;
            tag_row[0] <= row_in;
            tag_col[0] <= col_in;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_row[i] <= tag_row[i-1];
                tag_col[i] <= tag_col[i-1];
            end
        end
    end

    assign mem_re    = (state == ST_STREAM);
    assign mem_addr  = addr_q;
    assign buf_en    = (state == ST_PRIME);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign err       = err_q;
    assign win_valid = tag_v[PIPE_LAT-1];
    assign win_row   = tag_row[PIPE_LAT-1];
    assign win_col   = tag_col[PIPE_LAT-1];

endmodule

// File: tb/tb_linebuf_ctrl.sv
// Bench for linebuf_ctrl. A table of runs gives each config and its expected status timing.
// Each run pushes its expected window tags to a scoreboard queue when start is driven.
// Every win_valid from the DUT pops one entry from that queue and is compared against it.
// Inputs are driven and outputs are sampled at the negedge.
module tb_linebuf_ctrl;

    localparam int PIPE = 4;

    logic       clk = 1'b0;
    logic       xrst, start;
    logic [8:0] img_size, fil_size;
    logic       mem_re, buf_en, win_valid, busy, done, err;
    logic [17:0] mem_addr;
    logic [8:0] win_row, win_col;

    linebuf_ctrl dut (
        .clk       (clk),
        .xrst      (xrst),
        .start     (start),
        .img_size  (img_size),
        .fil_size  (fil_size),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .buf_en    (buf_en),
        .win_valid (win_valid),
        .win_row   (win_row),
        .win_col   (win_col),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int row;
        int col;
    } win_t;
    win_t sb[$];

    // kind: 0 plain run, 1 extra start while busy at cycle 30, 2 reset at cycle 40
    typedef struct {
        int img;
        int fil;
        int kind;
        int exp_err;
        int exp_wins;
        int exp_done;
    } vec_t;
    vec_t tbl[9];

    function automatic void chk(input string name, input int cyc, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    task automatic run_cfg(input vec_t v);
        int   n_last, wins, nsq;
        bit   legal;
        win_t w;
        legal = (v.exp_err == 0);
        nsq   = v.img * v.img;
        wins  = 0;
        sb.delete();
        if (legal)
            for (int r = 0; r < v.img; r++)
                for (int c = 0; c < v.img; c++)
                    if (r >= v.fil - 1 && c >= v.fil - 1)
                        sb.push_back('{2 + r * v.img + c + PIPE, r - v.fil + 1, c - v.fil + 1});
        n_last = legal ? v.exp_done + 1 : 3;
        for (int n = 0; n <= n_last; n++) begin
            @(negedge clk);
            if (v.kind == 2 && n == 41) begin
                chk("rst_busy", n, int'(busy), 0);
                chk("rst_mem_re", n, int'(mem_re), 0);
                chk("rst_mem_addr", n, int'(mem_addr), 0);
                chk("rst_buf_en", n, int'(buf_en), 0);
                chk("rst_win_valid", n, int'(win_valid), 0);
                chk("rst_win_row", n, int'(win_row), 0);
                chk("rst_win_col", n, int'(win_col), 0);
                chk("rst_done", n, int'(done), 0);
                chk("rst_err", n, int'(err), 0);
                xrst = 1'b0;
                sb.delete();
                break;
            end
            chk("busy", n, int'(busy), int'(legal && n >= 1 && n <= v.exp_done));
            chk("buf_en", n, int'(buf_en), int'(legal && n == 1));
            chk("mem_re", n, int'(mem_re), int'(legal && n >= 2 && n < 2 + nsq));
            if (legal && n >= 1)
                chk("mem_addr", n, int'(mem_addr), (n < 2) ? 0 : ((n < 2 + nsq) ? n - 2 : nsq - 1));
            chk("done", n, int'(done), int'(legal && n == v.exp_done));
            chk("err", n, int'(err), int'(!legal && n == 1));
            if (win_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL win_extra @cycle %0d: got window (%0d,%0d) expected none",
                             n, win_row, win_col);
                end else begin
                    w = sb.pop_front();
                    wins++;
                    chk("win_cycle", n, n, w.cyc);
                    chk("win_row", n, int'(win_row), w.row);
                    chk("win_col", n, int'(win_col), w.col);
                end
            end else begin
                chk("win_row_idle", n, int'(win_row), 0);
                chk("win_col_idle", n, int'(win_col), 0);
            end
            start    = (n == 0) || (v.kind == 1 && n == 30);
            img_size = (v.kind == 1 && n == 30) ? 9'd4 : 9'(v.img);
            fil_size = 9'(v.fil);
            xrst     = (v.kind == 2 && n == 40);
        end
        start = 1'b0;
        if (v.kind == 2) begin
            for (int k = 42; k <= 44; k++) begin
                @(negedge clk);
                chk("post_rst_busy", k, int'(busy), 0);
                chk("post_rst_win_valid", k, int'(win_valid), 0);
                chk("post_rst_done", k, int'(done), 0);
            end
        end else begin
            chk("win_count", n_last, wins, v.exp_wins);
            chk("win_missing", n_last, sb.size(), 0);
        end
    endtask

    initial begin
        tbl[0] = '{8, 3, 0, 0, 36, 70};
        tbl[1] = '{4, 1, 0, 0, 16, 22};
        tbl[2] = '{8, 6, 0, 1, 0, 0};
        tbl[3] = '{8, 0, 0, 1, 0, 0};
        tbl[4] = '{4, 5, 0, 1, 0, 0};
        tbl[5] = '{8, 3, 1, 0, 36, 70};
        tbl[6] = '{8, 3, 2, 0, 0, 70};
        tbl[7] = '{8, 3, 0, 0, 36, 70};
        tbl[8] = '{5, 5, 0, 0, 1, 31};

        xrst     = 1'b1;
        start    = 1'b0;
        img_size = '0;
        fil_size = '0;
        repeat (3) @(negedge clk);
        chk("init_busy", 0, int'(busy), 0);
        chk("init_mem_re", 0, int'(mem_re), 0);
        chk("init_mem_addr", 0, int'(mem_addr), 0);
        chk("init_buf_en", 0, int'(buf_en), 0);
        chk("init_win_valid", 0, int'(win_valid), 0);
        chk("init_done", 0, int'(done), 0);
        chk("init_err", 0, int'(err), 0);
        xrst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_cfg(tbl[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
